pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- RST_PULSE_CYCLES, 16: length of the pll_rst pulse in refclk cycles (min 1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles to wait for lock before a retry (1 ms at 50 MHz; min 1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release (min 1).
- CNT_WIDTH, 8: width of loss_count and retry_count.

REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- refclk, in, 1: sole clock, 50 MHz board reference.
- rst, in, 1: reset; one clock, synchronous, active-high.
- locked, in, 1: PLL lock indication; asynchronous to refclk.
- pll_rst, out, 1: reset to the PLL rst input, active-high.
- sys_rst, out, 1: reset to downstream logic, active-high.
- pll_ready, out, 1: high while the lock is qualified.
- timeout_err, out, 1: sticky flag, set on any lock timeout.
- loss_count, out, CNT_WIDTH: number of lock losses after qualification; saturating.
- retry_count, out, CNT_WIDTH: number of timeout-driven retries; saturating.

REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 locked SHALL pass through a 2-flop synchronizer to form locked_s; a change on locked sampled at edge N SHALL appear on locked_s after edge N+1.
REQ-005 The FSM SHALL have states RESET_PLL, WAIT_LOCK, STABLE and RUN, with one shared cycle counter that clears on every state entry.
REQ-006 In RESET_PLL:
- pll_rst=1.
- Exit to WAIT_LOCK after exactly RST_PULSE_CYCLES cycles in the state.
- locked_s is ignored.
REQ-007 In WAIT_LOCK:
- pll_rst=0.
- If locked_s=1, go to STABLE next cycle.
- Otherwise the counter increments; on reaching LOCK_TIMEOUT_CYCLES, go to RESET_PLL, set timeout_err and increment retry_count.
REQ-008 In STABLE:
- The counter increments each cycle while locked_s=1; on reaching LOCK_STABLE_CYCLES, go to RUN.
- Any cycle with locked_s=0 returns to WAIT_LOCK, with the timeout counter restarting from 0.
- This SHALL NOT count as a loss.
REQ-009 In RUN:
- pll_ready=1 and sys_rst=0.
- locked_s=0 SHALL go to RESET_PLL next cycle and increment loss_count.
REQ-010 Output decode:
- sys_rst=1 and pll_ready=0 in every state except RUN.
- pll_ready falls and sys_rst rises on the same edge that leaves RUN.
REQ-011 loss_count and retry_count SHALL saturate at 2^CNT_WIDTH-1 with no wrap.
REQ-012 timeout_err SHALL stay high until rst; it SHALL NOT affect the FSM.
REQ-013 Simultaneous events:
- rst overrides everything.
- In WAIT_LOCK, if locked_s=1 in the same cycle the counter reaches timeout, the transition SHALL be to STABLE (lock wins) with no error.
REQ-014 Counters SHALL be sized to hold the largest of the three cycle parameters; no overflow is permitted within a state.

Reset
REQ-015 While rst=1 the block SHALL hold:
- State RESET_PLL with counter=0.
- pll_rst=1, sys_rst=1, pll_ready=0.
- timeout_err=0, loss_count=0, retry_count=0.
- Synchronizer flops at 0.
REQ-016 After rst falls, pll_rst SHALL remain high for exactly RST_PULSE_CYCLES further cycles.
REQ-017 rst asserted in any state, including mid-count, SHALL restart the full sequence; no partial state survives.

Verification
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8.
REQ-018 Nominal bring-up:
- Stimulus: rst released at cycle 0; locked rises at cycle 20 and stays high.
- Response: pll_rst high for cycles 0-3; pll_ready rises at cycle 31 (±1 per the synchronizer definition, exact value fixed by REQ-004/008); sys_rst falls on the same edge; counts remain 0.
REQ-019 Timeout retry:
- Stimulus: locked held at 0.
- Response: pll_rst re-pulses for 4 cycles every 104 cycles; timeout_err sets at the first timeout; retry_count increments each time and saturates at 255.
REQ-020 Glitch during qualification:
- Stimulus: locked high for 5 cycles, low for 1 cycle, then high.
- Response: no pll_rst pulse; loss_count=0; pll_ready rises 8 cycles after the final synchronized rise plus the WAIT_LOCK→STABLE cycle.
REQ-021 Lock loss in RUN:
- Stimulus: in RUN, drop locked for 1 cycle.
- Response: loss_count 0→1; pll_ready=0 and sys_rst=1 starting 3 edges after the drop; a 4-cycle pll_rst pulse follows; re-qualification proceeds as in REQ-018.
REQ-022 Reset mid-sequence:
- Stimulus: assert rst for 1 cycle during STABLE with counter=5.
- Response: all outputs return to reset values; timeout_err and counts clear; a full 4-cycle pll_rst pulse restarts.
REQ-023 Tie-break:
- Stimulus: locked_s rises exactly on the cycle the WAIT_LOCK counter reaches 100.
- Response: transition to STABLE; timeout_err stays 0; retry_count unchanged.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for a qualified lock,
// then releases downstream reset; retries on lock timeout and counts lock losses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET_PLL | pll_rst asserted for RST_PULSE_CYCLES, lock input ignored
// WAIT_LOCK | PLL out of reset, waiting up to LOCK_TIMEOUT_CYCLES for lock
// STABLE    | lock seen, must hold for LOCK_STABLE_CYCLES consecutive cycles
// RUN       | lock qualified, downstream released
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int CNT_WIDTH           = 8
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 locked,
    output logic                 pll_rst,
    output logic                 sys_rst,
    output logic                 pll_ready,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] loss_count,
    output logic [CNT_WIDTH-1:0] retry_count
);

    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                     : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            sync_q1, locked_s;
    logic            retry_evt, loss_evt;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= RESET_PLL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_evt = 1'b0;
        loss_evt  = 1'b0;
        case (state)
            RESET_PLL: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                // lock takes priority over a coincident timeout
                if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TO_LAST) begin
                    state_nxt = RESET_PLL;
                    retry_evt = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s)             state_nxt = WAIT_LOCK;
                else if (cnt == STB_LAST)  state_nxt = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    state_nxt = RESET_PLL;
                    loss_evt  = 1'b1;
                end
            end
            default: state_nxt = RESET_PLL;
        endcase
        // RUN has no timing, so the counter is parked there instead of running free
        cnt_nxt = ((state_nxt != state) || (state == RUN)) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q1     <= 1'b0;
            locked_s    <= 1'b0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            pll_ready   <= 1'b0;
            timeout_err <= 1'b0;
            loss_count  <= '0;
            retry_count <= '0;
        end else begin
            sync_q1   <= locked;
            locked_s  <= sync_q1;
            pll_rst   <= (state_nxt == RESET_PLL);
            sys_rst   <= (state_nxt != RUN);
            pll_ready <= (state_nxt == RUN);
            if (retry_evt) timeout_err <= 1'b1;
            if (retry_evt && (retry_count != '1)) retry_count <= retry_count + CNT_WIDTH'(1);
            if (loss_evt && (loss_count != '1))   loss_count  <= loss_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: bring-up, lock loss, timeout,
// mid-sequence reset, qualification glitch, tie-break and retry saturation.
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, pll_ready, timeout_err;
    logic [7:0] loss_count, retry_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(100),
        .LOCK_STABLE_CYCLES (8),
        .CNT_WIDTH          (8)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .pll_ready  (pll_ready),
        .timeout_err(timeout_err),
        .loss_count (loss_count),
        .retry_count(retry_count)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk_reset_vals;
        chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_sys_rst", 32'(sys_rst), 1);
        chk("rst_ready",   32'(pll_ready), 0);
        chk("rst_tmo",     32'(timeout_err), 0);
        chk("rst_loss",    32'(loss_count), 0);
        chk("rst_retry",   32'(retry_count), 0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (3) tick();
        chk_reset_vals();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int er;
        do_reset();

        // nominal bring-up: locked rises in cycle 20, RUN from cycle 31
        while (cyc < 35) begin
            if (cyc == 20) locked = 1'b1;
            chk("nom_pll_rst", 32'(pll_rst),   32'(cyc < 4));
            chk("nom_ready",   32'(pll_ready), 32'(cyc >= 31));
            chk("nom_sys_rst", 32'(sys_rst),   32'(cyc < 31));
            tick();
        end
        chk("nom_loss",  32'(loss_count), 0);
        chk("nom_retry", 32'(retry_count), 0);

        // one-cycle lock drop in RUN at cycle 40
        while (cyc < 60) begin
            if (cyc == 40) locked = 1'b0;
            if (cyc == 41) locked = 1'b1;
            chk("loss_ready",   32'(pll_ready), 32'(!(cyc >= 43 && cyc < 56)));
            chk("loss_sys_rst", 32'(sys_rst),   32'(cyc >= 43 && cyc < 56));
            chk("loss_pll_rst", 32'(pll_rst),   32'(cyc >= 43 && cyc <= 46));
            if (cyc == 43) chk("loss_cnt_step", 32'(loss_count), 1);
            tick();
        end
        chk("loss_cnt",   32'(loss_count), 1);
        chk("loss_retry", 32'(retry_count), 0);

        // permanent loss at cycle 60, one timeout, then reset during STABLE cnt=5
        locked = 1'b0;
        while (cyc < 179) begin
            if (cyc == 171) locked = 1'b1;
            chk("tmo_pll_rst", 32'(pll_rst),
                32'((cyc >= 63 && cyc <= 66) || (cyc >= 167 && cyc <= 170)));
            chk("tmo_ready",   32'(pll_ready), 32'(cyc < 63));
            chk("tmo_err",     32'(timeout_err), 32'(cyc >= 167));
            chk("tmo_retry",   32'(retry_count), 32'(cyc >= 167));
            tick();
        end
        chk("tmo_loss", 32'(loss_count), 2);
        rst = 1'b1;
        tick();
        chk_reset_vals();
        rst = 1'b0;
        cyc = 0;
        while (cyc < 15) begin
            chk("mid_pll_rst", 32'(pll_rst),   32'(cyc < 4));
            chk("mid_ready",   32'(pll_ready), 32'(cyc >= 13));
            tick();
        end

        // glitch during qualification: high 10-14, low 15, high from 16
        locked = 1'b0;
        do_reset();
        while (cyc < 29) begin
            if (cyc == 10) locked = 1'b1;
            if (cyc == 15) locked = 1'b0;
            if (cyc == 16) locked = 1'b1;
            chk("gl_pll_rst", 32'(pll_rst),   32'(cyc < 4));
            chk("gl_ready",   32'(pll_ready), 32'(cyc >= 27));
            tick();
        end
        chk("gl_loss", 32'(loss_count), 0);

        // tie-break: locked_s first high on the final WAIT_LOCK cycle (103)
        locked = 1'b0;
        do_reset();
        while (cyc < 113) begin
            if (cyc == 101) locked = 1'b1;
            chk("tie_pll_rst", 32'(pll_rst),   32'(cyc < 4));
            chk("tie_ready",   32'(pll_ready), 32'(cyc >= 112));
            chk("tie_err",     32'(timeout_err), 0);
            tick();
        end
        chk("tie_retry", 32'(retry_count), 0);

        // retry every 104 cycles with saturation at 255
        locked = 1'b0;
        do_reset();
        for (int k = 1; k <= 258; k++) begin
            goto(104 * k - 1);
            er = (k - 1 > 255) ? 255 : k - 1;
            chk("sat_pre_pll_rst", 32'(pll_rst), 0);
            chk("sat_pre_retry",   32'(retry_count), 32'(er));
            chk("sat_pre_err",     32'(timeout_err), 32'(k > 1));
            tick();
            er = (k > 255) ? 255 : k;
            chk("sat_pll_rst", 32'(pll_rst), 1);
            chk("sat_retry",   32'(retry_count), 32'(er));
            chk("sat_err",     32'(timeout_err), 1);
            goto(104 * k + 3);
            chk("sat_end_pll_rst", 32'(pll_rst), 1);
            tick();
            chk("sat_wait_pll_rst", 32'(pll_rst), 0);
        end
        chk("sat_loss", 32'(loss_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
